memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Round-robin arbiter granting exclusive access to one shared 8-bit-address, 32-bit-data memory port among `NUM_CLIENTS` requesters. It sits directly downstream of the memory client modules, such as the atomic incrementer and the periodic reader. It consumes each client's `requestingMemory`/`address`/`readWrite`/`outputData` and returns `grantedAccess` plus broadcast read data. The memory port faces a single-port BRAM with one-cycle registered read latency.

## Interface
- `NUM_CLIENTS`, 4: number of requesters (2..8).
- `ADDR_WIDTH`, 8: address width.
- `DATA_WIDTH`, 32: data width.
- `MAX_HOLD`, 16: maximum consecutive cycles one grant may be held before forced release.

- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high reset.
- `requests` in NUM_CLIENTS: bit i = client i `requestingMemory`.
- `grants` out NUM_CLIENTS: bit i = client i `grantedAccess`; registered, at most one bit set.
- `addresses` in NUM_CLIENTS*ADDR_WIDTH: client i address in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `readWrites` in NUM_CLIENTS: client i readWrite (1 = read, 0 = write).
- `clientData` in NUM_CLIENTS*DATA_WIDTH: client i write data, packed like `addresses`.
- `dataToClients` out DATA_WIDTH: memory read data, broadcast to all clients' `inputData`.
- `memAddress` out ADDR_WIDTH: address of current owner; 0 when no owner.
- `memWriteEnable` out 1: write strobe to memory.
- `memDataOut` out DATA_WIDTH: write data of current owner; 0 when no owner.
- `memDataIn` in DATA_WIDTH: memory read data, valid one cycle after address.
- `timeoutFlag` out 1: sticky; set on any forced release, cleared only by reset.

## Operation
- States: IDLE, GRANTED, RELEASE. Owner index `owner` and round-robin pointer `lastOwner` are registered.
- IDLE: if any `requests` bit is set, pick the first set bit searching from `lastOwner+1` upward modulo NUM_CLIENTS.
  - Load `owner`, set `grants[owner]`, clear hold counter, go to GRANTED.
  - If no request is pending, stay in IDLE.
- GRANTED: the hold counter increments each cycle.
  - If `requests[owner]` is 0: clear `grants`, set `lastOwner <= owner`, go to RELEASE.
  - Else if the hold counter reaches MAX_HOLD-1: forced release with the same actions, and set `timeoutFlag`.
- RELEASE: one mandatory idle cycle with `grants` = 0, then go to IDLE. This guarantees every client observes grant low between owners.
- Memory mux, combinational from registered `owner`/state:
  - In GRANTED, `memAddress`/`memDataOut` come from the owner slice; otherwise both are 0.
  - `memWriteEnable = (state==GRANTED) & requests[owner] & ~readWrites[owner]`. A request dropping blocks any stray write.
- `dataToClients = memDataIn`, unconditionally. Clients sample it only while owning.
- Requests from non-owners are ignored until IDLE; they may stay asserted indefinitely.
- A request dropped before grant is simply not selected. A request asserted and dropped within IDLE is lost, which is acceptable.
- Owner index width is clog2(NUM_CLIENTS). Hold counter width is clog2(MAX_HOLD)+1. Round-robin wrap: after index NUM_CLIENTS-1, search continues at 0.

## Timing
- Reset values: `grants`=0, state IDLE, `lastOwner`=NUM_CLIENTS-1 (client 0 has first priority), `owner`=0, hold counter 0, `timeoutFlag`=0. `memAddress`, `memDataOut` and `memWriteEnable` are therefore 0.
- Grant latency: request seen high at edge N in IDLE gives `grants` high after edge N (cycle N+1).
- Read: address is driven from the first grant cycle; `memDataIn` is valid the following cycle. A client that samples in the cycle after it sees the grant gets correct data.
- Release: `requests[owner]` low at edge N gives `grants` low from cycle N+1, RELEASE in N+1, and the next grant at the earliest in cycle N+3.
- Simultaneous requests: round-robin order; each client waits at most NUM_CLIENTS-1 tenures.
- Reset mid-GRANTED: `grants` clears on the next edge; no write is issued in the reset cycle after the edge.

## Test plan
- Reset, then client 0 requests address 0x18 read: `grants`=0001 one cycle later; `memAddress`=0x18; `dataToClients` equals BRAM[0x18] on the following cycle.
- Atomic-increment sequence on client 1 with BRAM[0x18]=5: exactly one `memWriteEnable` pulse with `memDataOut`=6; BRAM[0x18]=6 afterwards.
- Clients 0..3 all request and hold 3 cycles each: grant order 0,1,2,3,0; exactly one RELEASE cycle with `grants`=0 between tenures.
- Client 2 holds its request for 40 cycles with MAX_HOLD=16: grant drops after 16 cycles, `timeoutFlag`=1, client 3 is granted next if it is requesting.
- `reset` asserted mid-write tenure: `grants`, `memWriteEnable` and `timeoutFlag` are 0 after the edge; after reset, client 0 is served first.
- Owner drops its request with readWrite=0 still set: `memWriteEnable` falls in the same cycle; no write occurs in the trailing grant cycle.

Source files
------------

// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
//
// Round-robin arbiter that gives NUM_CLIENTS requesters exclusive, one-at-a-
// time access to a single shared memory port. The memory behind the port is a
// single-port block RAM with a one-cycle registered read.
//
// Ports
//   clk            : single clock, everything on the rising edge
//   reset          : synchronous, active-high
//   requests       : bit i = client i wants the memory
//   grants         : bit i = client i owns the memory (registered, one-hot/zero)
//   addresses      : client i address in [i*ADDR_WIDTH +: ADDR_WIDTH]
//   readWrites     : client i direction, 1 = read, 0 = write
//   clientData     : client i write data in [i*DATA_WIDTH +: DATA_WIDTH]
//   dataToClients  : memory read data broadcast to every client
//   memAddress     : address of the current owner, 0 with no owner
//   memWriteEnable : write strobe to the memory
//   memDataOut     : write data of the current owner, 0 with no owner
//   memDataIn      : memory read data, valid one cycle after the address
//   timeoutFlag    : sticky, set by any forced release, cleared by reset
// ---------------------------------------------------------------------------
module memory_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_HOLD    = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CLIENTS-1:0]            requests,
  output logic [NUM_CLIENTS-1:0]            grants,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addresses,
  input  logic [NUM_CLIENTS-1:0]            readWrites,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] clientData,
  output logic [DATA_WIDTH-1:0]             dataToClients,
  output logic [ADDR_WIDTH-1:0]             memAddress,
  output logic                              memWriteEnable,
  output logic [DATA_WIDTH-1:0]             memDataOut,
  input  logic [DATA_WIDTH-1:0]             memDataIn,
  output logic                              timeoutFlag
);

  localparam int OW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int HW = $clog2(MAX_HOLD) + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANTED = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [OW-1:0]          LAST_CLIENT = OW'(NUM_CLIENTS - 1);
  localparam logic [HW-1:0]          HOLD_LIMIT  = HW'(MAX_HOLD - 1);
  localparam logic [NUM_CLIENTS-1:0] ONE_HOT0    = {{(NUM_CLIENTS-1){1'b0}}, 1'b1};

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]             state_q,      state_d;
  logic [OW-1:0]          owner_q,      owner_d;
  logic [OW-1:0]          last_owner_q, last_owner_d;
  logic [HW-1:0]          hold_q,       hold_d;
  logic [NUM_CLIENTS-1:0] grants_q,     grants_d;
  logic                   timeout_q,    timeout_d;

  // -------------------------------------------------------------------------
  // Per-client views of the packed buses
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_CLIENTS];
  logic [DATA_WIDTH-1:0] data_arr [NUM_CLIENTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
      assign addr_arr[gi] = addresses[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_arr[gi] = clientData[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin search
  //
  // Candidate gi is the client (gi+1) places after the previous owner,
  // wrapping modulo NUM_CLIENTS. Candidate 0 has the highest priority, so the
  // previous owner itself (candidate NUM_CLIENTS-1) is considered last.
  // -------------------------------------------------------------------------
  logic [OW-1:0]          cand_idx  [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] cand_req;
  logic [OW-1:0]          chain_idx [NUM_CLIENTS+1];
  logic                   pick_valid;
  logic [OW-1:0]          pick_idx;

  generate
    for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_cand
      logic [OW:0] sum;
      assign sum           = {1'b0, last_owner_q} + (OW+1)'(gi + 1);
      assign cand_idx[gi]  = (sum >= (OW+1)'(NUM_CLIENTS))
                             ? OW'(sum - (OW+1)'(NUM_CLIENTS))
                             : sum[OW-1:0];
      assign cand_req[gi]  = requests[cand_idx[gi]];
    end

    // Priority chain: the lowest-numbered requesting candidate wins.
    assign chain_idx[NUM_CLIENTS] = last_owner_q;
    for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_chain
      assign chain_idx[gi] = cand_req[gi] ? cand_idx[gi] : chain_idx[gi+1];
    end
  endgenerate

  assign pick_valid = |cand_req;
  assign pick_idx   = chain_idx[0];

  // -------------------------------------------------------------------------
  // Owner view
  // -------------------------------------------------------------------------
  logic granted;
  logic owner_req;
  logic owner_rd;

  assign granted   = (state_q == ST_GRANTED);
  assign owner_req = requests[owner_q];
  assign owner_rd  = readWrites[owner_q];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    hold_d       = hold_q;
    grants_d     = grants_q;
    timeout_d    = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d  = pick_idx;
          grants_d = ONE_HOT0 << pick_idx;
          hold_d   = '0;
          state_d  = ST_GRANTED;
        end
      end

      ST_GRANTED: begin
        if (!owner_req) begin
          // Voluntary release.
          grants_d     = '0;
          last_owner_d = owner_q;
          state_d      = ST_RELEASE;
        end else if (hold_q == HOLD_LIMIT) begin
          // Owner has held the port MAX_HOLD cycles: take it away.
          grants_d     = '0;
          last_owner_d = owner_q;
          timeout_d    = 1'b1;
          state_d      = ST_RELEASE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      ST_RELEASE: begin
        // One guaranteed cycle with every grant low between owners.
        state_d = ST_IDLE;
      end

      default: begin
        grants_d = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_CLIENT;   // client 0 is searched first after reset
      hold_q       <= '0;
      grants_q     <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      hold_q       <= hold_d;
      grants_q     <= grants_d;
      timeout_q    <= timeout_d;
    end
  end

  // -------------------------------------------------------------------------
  // Memory port mux
  //
  // The write strobe also looks at the live request bit, so an owner that
  // drops its request cannot produce a write in its trailing grant cycle.
  // -------------------------------------------------------------------------
  assign memAddress     = granted ? addr_arr[owner_q] : '0;
  assign memDataOut     = granted ? data_arr[owner_q] : '0;
  assign memWriteEnable = granted & owner_req & ~owner_rd;

  assign dataToClients  = memDataIn;
  assign grants         = grants_q;
  assign timeoutFlag    = timeout_q;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

  localparam int NC = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MH = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NC-1:0]     requests = '0;
  logic [NC-1:0]     readWrites = '1;
  logic [NC*AW-1:0]  addresses = '0;
  logic [NC*DW-1:0]  clientData = '0;
  logic [NC-1:0]     grants;
  logic [DW-1:0]     dataToClients;
  logic [AW-1:0]     memAddress;
  logic              memWriteEnable;
  logic [DW-1:0]     memDataOut;
  logic [DW-1:0]     memDataIn;
  logic              timeoutFlag;

  memory_arbiter #(
    .NUM_CLIENTS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MH)
  ) dut (
    .clk(clk), .reset(reset), .requests(requests), .grants(grants),
    .addresses(addresses), .readWrites(readWrites), .clientData(clientData),
    .dataToClients(dataToClients), .memAddress(memAddress),
    .memWriteEnable(memWriteEnable), .memDataOut(memDataOut),
    .memDataIn(memDataIn), .timeoutFlag(timeoutFlag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Block RAM behind the port: one-cycle registered read, contents set on reset.
  logic [DW-1:0] mem [256];
  int wr_pulses;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i) + 32'h100;
      mem[8'h18] <= 32'd5;
      wr_pulses <= 0;
    end else begin
      if (memWriteEnable === 1'b1) begin
        mem[memAddress] <= memDataOut;
        wr_pulses <= wr_pulses + 1;
      end
    end
    memDataIn <= mem[memAddress];
  end

  // Reference model: who owns the port, how long it has held it, and whether
  // we are in the mandatory gap after a tenure. Phase 0 = free, 1 = owned,
  // 2 = gap cycle.
  int m_phase = 0;
  int m_owner = 0;
  int m_last = NC - 1;
  int m_tenure = 0;
  logic m_timeout = 1'b0;

  // Tenure log built from the DUT grant waveform.
  int own_q[$];
  int start_q[$];
  int len_q[$];
  int cyc = 0;
  int run_len = 0;
  logic [NC-1:0] prev_g = '0;

  initial begin
    logic [NC-1:0] one_v;
    logic [NC-1:0] exp_g;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    logic          exp_we;
    int            c;
    int            idx;
    bit            found;
    one_v = 1;
    forever begin
      @(negedge clk);
      cyc++;
      // Inputs are stable from here to the next rising edge.
      exp_g  = (m_phase == 1) ? (one_v << m_owner) : '0;
      exp_a  = (m_phase == 1) ? addresses[m_owner*AW +: AW] : '0;
      exp_d  = (m_phase == 1) ? clientData[m_owner*DW +: DW] : '0;
      exp_we = (m_phase == 1) && requests[m_owner] && !readWrites[m_owner];
      check("grants", grants, exp_g);
      check("memAddress", memAddress, exp_a);
      check("memDataOut", memDataOut, exp_d);
      check("memWriteEnable", memWriteEnable, exp_we);
      check("timeoutFlag", timeoutFlag, m_timeout);
      check("dataToClients", dataToClients, memDataIn);

      // tenure log
      if (grants != 0 && prev_g == 0) begin
        idx = 0;
        for (int i = 0; i < NC; i++) if (grants[i]) idx = i;
        own_q.push_back(idx);
        start_q.push_back(cyc);
        run_len = 0;
      end
      if (grants != 0) run_len++;
      if (grants == 0 && prev_g != 0) len_q.push_back(run_len);
      prev_g = grants;

      // advance model to what the coming edge produces
      if (reset) begin
        m_phase = 0; m_owner = 0; m_last = NC - 1; m_tenure = 0; m_timeout = 1'b0;
      end else if (m_phase == 0) begin
        found = 1'b0;
        for (int k = 1; k <= NC; k++) begin
          c = (m_last + k) % NC;
          if (!found && requests[c]) begin
            found = 1'b1; m_owner = c; m_phase = 1; m_tenure = 1;
          end
        end
      end else if (m_phase == 1) begin
        if (!requests[m_owner]) begin
          m_phase = 2; m_last = m_owner;
        end else if (m_tenure == MH) begin
          m_phase = 2; m_last = m_owner; m_timeout = 1'b1;
        end else begin
          m_tenure++;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_client(input int i, input logic req, input logic rw,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    requests[i] = req;
    readWrites[i] = rw;
    addresses[i*AW +: AW] = a;
    clientData[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int b, lb, wb;
    int cnt[NC];
    int exp_order[5];
    logic [DW-1:0] rd;
    exp_order = '{0, 1, 2, 3, 0};

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    tick();
    check("rst_grants", grants, 4'b0000);
    check("rst_timeout", timeoutFlag, 1'b0);
    check("rst_memAddress", memAddress, 8'h00);
    check("rst_memWriteEnable", memWriteEnable, 1'b0);
    check("rst_memDataOut", memDataOut, 32'h0);
    $display("reset: grants=%b timeout=%b", grants, timeoutFlag);

    // ---------------- client 0 read of 0x18 ----------------
    set_client(0, 1'b1, 1'b1, 8'h18, 32'h0);
    tick();
    check("rd_grant", grants, 4'b0001);
    check("rd_addr", memAddress, 8'h18);
    tick();
    check("rd_data", dataToClients, 32'd5);
    $display("read c0 @18: grants=%b data=%0d", grants, dataToClients);
    requests[0] = 1'b0;
    repeat (3) tick();

    // ---------------- atomic increment by client 1 ----------------
    wb = wr_pulses;
    set_client(1, 1'b1, 1'b1, 8'h18, 32'h0);
    tick();
    check("inc_grant", grants, 4'b0010);
    tick();
    check("inc_read", dataToClients, 32'd5);
    rd = dataToClients;
    readWrites[1] = 1'b0;
    clientData[1*DW +: DW] = rd + 32'd1;
    #1;
    check("inc_we", memWriteEnable, 1'b1);
    check("inc_wdata", memDataOut, 32'd6);
    tick();
    requests[1] = 1'b0;     // drop with readWrite still 0
    #1;
    check("drop_grant_still", grants, 4'b0010);
    check("drop_we_low", memWriteEnable, 1'b0);
    repeat (3) tick();
    check("inc_pulses", 64'(wr_pulses - wb), 64'd1);
    check("inc_mem", mem[8'h18], 32'd6);
    $display("increment c1 @18: pulses=%0d mem=%0d", wr_pulses - wb, mem[8'h18]);
    readWrites[1] = 1'b1;

    // ---------------- four clients, 3-cycle tenures ----------------
    do_reset();
    b = own_q.size();
    lb = len_q.size();
    for (int i = 0; i < NC; i++) begin
      set_client(i, 1'b1, 1'b1, 8'(8'h40 + i), 32'h0);
      cnt[i] = 0;
    end
    for (int n = 0; n < 200 && own_q.size() < b + 5; n++) begin
      tick();
      for (int i = 0; i < NC; i++) begin
        if (grants[i]) begin
          cnt[i]++;
          if (cnt[i] >= 3) requests[i] = 1'b0;
        end else if (!requests[i]) begin
          requests[i] = 1'b1;
          cnt[i] = 0;
        end
      end
    end
    requests = '0;
    repeat (4) tick();
    check("rr_count", 64'(own_q.size() >= b + 5), 64'd1);
    if (own_q.size() >= b + 5 && len_q.size() >= lb + 4) begin
      for (int k = 0; k < 5; k++) begin
        check("rr_order", 64'(own_q[b+k]), 64'(exp_order[k]));
        $display("rr tenure %0d: client %0d at cycle %0d", k, own_q[b+k], start_q[b+k]);
      end
      for (int k = 0; k < 4; k++) begin
        // 3 grant cycles, then the release cycle and one idle cycle
        check("rr_spacing", 64'(start_q[b+k+1] - start_q[b+k]), 64'd5);
        check("rr_len", 64'(len_q[lb+k]), 64'd3);
      end
    end

    // ---------------- forced release of client 2 ----------------
    b = own_q.size();
    lb = len_q.size();
    cnt[3] = 0;
    set_client(2, 1'b1, 1'b1, 8'h22, 32'h0);
    set_client(3, 1'b1, 1'b1, 8'h33, 32'h0);
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 10) check("to_flag_before", timeoutFlag, 1'b0);
      if (n == 17) begin
        check("to_flag_after", timeoutFlag, 1'b1);
        check("to_grant_dropped", grants, 4'b0000);
      end
      if (grants[3]) begin
        cnt[3]++;
        if (cnt[3] >= 2) requests[3] = 1'b0;
      end
    end
    requests = '0;
    repeat (4) tick();
    check("to_count", 64'(own_q.size() >= b + 2 && len_q.size() >= lb + 1), 64'd1);
    if (own_q.size() >= b + 2 && len_q.size() >= lb + 1) begin
      check("to_first", 64'(own_q[b]), 64'd2);
      check("to_len", 64'(len_q[lb]), 64'd16);
      check("to_next", 64'(own_q[b+1]), 64'd3);
      $display("timeout: c2 held %0d, next client %0d, flag=%b", len_q[lb], own_q[b+1], timeoutFlag);
    end
    check("to_sticky", timeoutFlag, 1'b1);

    // ---------------- reset during a write tenure ----------------
    set_client(1, 1'b1, 1'b0, 8'h20, 32'hDEADBEEF);
    tick();
    check("rw_grant", grants, 4'b0010);
    check("rw_we", memWriteEnable, 1'b1);
    reset = 1'b1;
    tick();
    check("rw_rst_grants", grants, 4'b0000);
    check("rw_rst_we", memWriteEnable, 1'b0);
    check("rw_rst_timeout", timeoutFlag, 1'b0);
    reset = 1'b0;
    set_client(0, 1'b1, 1'b1, 8'h10, 32'h0);
    tick();
    check("rw_first_after_rst", grants, 4'b0001);
    $display("reset mid-write: grants after restart=%b", grants);
    requests = '0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
